pw_multi_pattern_matcher: RTL
=============================

// Module: pw_multi_pattern_matcher
// PURPOSE
//  Successor to the single-pattern front-end matcher: compares the USB front-end byte stream against
//  pNUM_PATTERNS independent masked patterns, counts matching events and fires the trigger on the Nth.
//  Sits between the capture block (fe data/valid/capturing) and the trigger block; config from reg block.
//  Single clock domain; all register-block inputs are already synchronous to fe_clk.
// PARAMETERS
//  pPATTERN_BYTES  8   max pattern length in bytes (>=2)
//  pNUM_PATTERNS   4   number of independent pattern channels (1..8)
//  pCOUNT_WIDTH    16  width of match-event counter / target
// PORTS
//  fe_clk           in   1                     sole clock
//  reset_i          in   1                     synchronous, active-high reset
//  I_arm            in   1                     level; 1 = matching enabled
//  I_pattern        in   pNUM_PATTERNS*pPATTERN_BYTES*8  channel k at [k*W+:W], W=pPATTERN_BYTES*8; byte0 = newest
//  I_mask           in   pNUM_PATTERNS*pPATTERN_BYTES*8  per-bit compare mask, same layout
//  I_pattern_bytes  in   pNUM_PATTERNS*8       channel length; 0 = channel disabled
//  I_match_count    in   pCOUNT_WIDTH          fire on this match event (0 treated as 1)
//  I_fe_data        in   8                     front-end data byte
//  I_fe_data_valid  in   1                     byte qualifier
//  I_capturing      in   1                     capture in progress
//  O_match_trigger  out  1                     1-cycle trigger pulse
//  O_match_id       out  3                     lowest matching channel of firing event
//  O_match_vec      out  pNUM_PATTERNS         channels matching at firing event
//  O_event_count    out  pCOUNT_WIDTH          match events seen since arm/clear
//  O_state          out  2                     FSM state (debug)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, history/byte counter/event counter cleared.
//  Pipeline: I_fe_data/valid registered (stage1); compare on stage1 byte + (pPATTERN_BYTES-1)-byte history
//   shifted only on stage1 valid in ARMED; O_match_trigger high exactly 2 cycles after I_fe_data_valid.
//  Byte counter: +1 per accepted byte, saturates at 8'hFF.
//  Channel k hit: masked {history,byte}==masked pattern_k over full width AND len_k!=0 AND bytes_rx>=len_k-1;
//   len_k>pPATTERN_BYTES clamped to pPATTERN_BYTES. Unused bytes must be masked by software.
//  Event: any channel hit on an accepted byte = one event (several channels same byte = one event).
//  FSM: IDLE -(I_arm)-> ARMED. ARMED: on event, count+1; if count+1 >= max(I_match_count,1): pulse,
//   latch O_match_id/O_match_vec, -> TRIGGERED. ARMED -(!I_arm)-> IDLE, clear history/counters.
//   TRIGGERED: no shifting/compare; on I_capturing falling edge (1->0) clear history, byte & event counters,
//   -> ARMED if I_arm else IDLE; O_match_id/vec held until next firing. !I_arm in TRIGGERED -> IDLE.
//  Simultaneous: capture-done clear and valid byte same cycle -> clear wins, byte dropped.
//   !I_arm and event same cycle -> disarm wins, no pulse.
//  Event counter saturates at all-ones; O_match_trigger never held >1 cycle; no re-fire until cleared.
//  Reset mid-operation: immediate return to reset state next edge, in-flight byte discarded.
// TESTING
//  1 ch0 pattern 0xDEADBEEF len4 mask 0xFFFFFFFF, count=1; stream 11 DE AD BE EF -> pulse 2 clk after EF, id=0.
//  2 ch1 len2 'A5 5A', ch3 len2 same; stream A5 5A -> one pulse, id=1, vec=4'b1010, event_count=1.
//  3 count=3, ch0 len1 0x7E; stream 7E 00 7E 7E -> pulse only on 3rd 7E, event_count=3.
//  4 len3 pattern, only 2 bytes received after arm -> no pulse despite masked match.
//  5 after trigger, drop I_capturing -> counters 0, state ARMED; repeat pattern -> second pulse.
//  6 reset_i and I_arm drop mid-pattern -> no pulse; state IDLE; all outputs 0 after reset.

Source files
------------

// File: rtl/pw_multi_pattern_matcher.sv
// Multi-channel masked byte-pattern matcher for the USB front-end stream.
// Counts match events across all channels and pulses the trigger on the Nth.
module pw_multi_pattern_matcher #(
    parameter int pPATTERN_BYTES = 8,
    parameter int pNUM_PATTERNS  = 4,
    parameter int pCOUNT_WIDTH   = 16
) (
    input  logic                                    fe_clk,
    input  logic                                    reset_i,
    input  logic                                    I_arm,
    input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_pattern,
    input  logic [pNUM_PATTERNS*pPATTERN_BYTES*8-1:0] I_mask,
    input  logic [pNUM_PATTERNS*8-1:0]              I_pattern_bytes,
    input  logic [pCOUNT_WIDTH-1:0]                 I_match_count,
    input  logic [7:0]                              I_fe_data,
    input  logic                                    I_fe_data_valid,
    input  logic                                    I_capturing,
    output logic                                    O_match_trigger,
    output logic [2:0]                              O_match_id,
    output logic [pNUM_PATTERNS-1:0]                O_match_vec,
    output logic [pCOUNT_WIDTH-1:0]                 O_event_count,
    output logic [1:0]                              O_state
);

    localparam int W  = pPATTERN_BYTES * 8;
    localparam int HW = W - 8;
    localparam logic [7:0] LEN_MAX = 8'(pPATTERN_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_TRIG  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    function automatic logic [pCOUNT_WIDTH-1:0] sat_inc_cnt(input logic [pCOUNT_WIDTH-1:0] v);
        return (&v) ? v : v + pCOUNT_WIDTH'(1);
    endfunction

    function automatic logic [2:0] lowest_id(input logic [pNUM_PATTERNS-1:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int k = pNUM_PATTERNS - 1; k >= 0; k--) begin
            if (v[k]) id = k[2:0];
        end
        return id;
    endfunction

    state_t                     r_state;
    logic [7:0]                 r_data_p1;
    logic                       r_vld_p1;
    logic                       r_cap_d;
    logic [HW-1:0]              r_hist;
    logic [7:0]                 r_bytes_rx;
    logic [pCOUNT_WIDTH-1:0]    r_event_cnt;
    logic                       r_trig;
    logic [2:0]                 r_match_id;
    logic [pNUM_PATTERNS-1:0]   r_match_vec;

    logic [W-1:0]               w_window;
    logic [pNUM_PATTERNS-1:0]   w_hit_vec;
    logic                       w_accept;
    logic                       w_event;
    logic                       w_cap_fall;
    logic [pCOUNT_WIDTH-1:0]    w_cnt_inc;
    logic [pCOUNT_WIDTH-1:0]    w_target;

    // Stage 1: register the front-end byte and its qualifier
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_vld_p1 <= 1'b0;
            r_cap_d  <= 1'b0;
        end else begin
            r_vld_p1 <= I_fe_data_valid;
            r_cap_d  <= I_capturing;
        end
    end

    always_ff @(posedge fe_clk) begin
        r_data_p1 <= I_fe_data;
    end

    // Byte0 of the window is the newest byte, older bytes come from history
    assign w_window = {r_hist, r_data_p1};

    genvar k;
    for (k = 0; k < pNUM_PATTERNS; k++) begin : g_ch
        logic [7:0] w_len;
        assign w_len = (I_pattern_bytes[k*8 +: 8] > LEN_MAX) ? LEN_MAX : I_pattern_bytes[k*8 +: 8];
        assign w_hit_vec[k] = ((w_window & I_mask[k*W +: W]) == (I_pattern[k*W +: W] & I_mask[k*W +: W]))
                              && (w_len != 8'd0)
                              && (({1'b0, r_bytes_rx} + 9'd1) >= {1'b0, w_len});
    end

    // A byte counts only while armed; a same-cycle disarm drops it
    assign w_accept   = r_vld_p1 && (r_state == ST_ARMED) && I_arm;
    assign w_event    = w_accept && (|w_hit_vec);
    assign w_cap_fall = r_cap_d && !I_capturing;
    assign w_cnt_inc  = sat_inc_cnt(r_event_cnt);
    assign w_target   = (I_match_count == '0) ? pCOUNT_WIDTH'(1) : I_match_count;

    // Stage 2: event counting, trigger FSM and registered outputs
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_hist      <= '0;
            r_bytes_rx  <= 8'd0;
            r_event_cnt <= '0;
            r_trig      <= 1'b0;
            r_match_id  <= 3'd0;
            r_match_vec <= '0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (I_arm) r_state <= ST_ARMED;
                end
                ST_ARMED: begin
                    if (!I_arm) begin
                        r_state     <= ST_IDLE;
                        r_hist      <= '0;
                        r_bytes_rx  <= 8'd0;
                        r_event_cnt <= '0;
                    end else if (w_accept) begin
                        r_hist     <= w_window[HW-1:0];
                        r_bytes_rx <= sat_inc8(r_bytes_rx);
                        if (w_event) begin
                            r_event_cnt <= w_cnt_inc;
                            if (w_cnt_inc >= w_target) begin
                                r_trig      <= 1'b1;
                                r_match_id  <= lowest_id(w_hit_vec);
                                r_match_vec <= w_hit_vec;
                                r_state     <= ST_TRIG;
                            end
                        end
                    end
                end
                ST_TRIG: begin
                    if (!I_arm || w_cap_fall) begin
                        r_state     <= I_arm ? ST_ARMED : ST_IDLE;
                        r_hist      <= '0;
                        r_bytes_rx  <= 8'd0;
                        r_event_cnt <= '0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign O_match_trigger = r_trig;
    assign O_match_id      = r_match_id;
    assign O_match_vec     = r_match_vec;
    assign O_event_count   = r_event_cnt;
    assign O_state         = r_state;

endmodule
